// File: rtl/magnetron_ctrl.sv
// Magnetron driver: run/stop state machine with PWM power control, door
// interlock and an enforced cooldown period before the next start.
module magnetron_ctrl #(
   parameter int PWR_W   = 4,
   parameter int MIN_OFF = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set,
   input  logic             reset,
   input  logic             door_open,
   input  logic [PWR_W-1:0] power,
   output logic             mag_on,
   output logic             active,
   output logic             cooldown
);

   localparam int CNT_W = (MIN_OFF > 0) ? $clog2(MIN_OFF + 1) : 1;

   typedef enum logic [1:0] {IDLE, RUN, COOL} state_t;

   state_t           state, state_nxt;
   logic [PWR_W-1:0] phase, phase_nxt;
   logic [PWR_W-1:0] power_q, power_q_nxt;
   logic [CNT_W-1:0] cool_cnt, cool_cnt_nxt;
   logic             stop_req;

   assign stop_req = reset | door_open;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         phase    <= '0;
         power_q  <= '0;
         cool_cnt <= '0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         power_q  <= power_q_nxt;
         cool_cnt <= cool_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      power_q_nxt  = power_q;
      cool_cnt_nxt = cool_cnt;
      unique case (state)
         IDLE: begin
            if (set && !stop_req) begin
               state_nxt   = RUN;
               phase_nxt   = '0;
               power_q_nxt = power;
            end
         end
         RUN: begin
            if (stop_req) begin
               phase_nxt = '0;
               if (MIN_OFF == 0) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt    = COOL;
                  cool_cnt_nxt = CNT_W'(MIN_OFF);
               end
            end else begin
               phase_nxt = phase + 1'b1;
               // new power level is only picked up at a period boundary
               if (phase == '1) power_q_nxt = power;
            end
         end
         COOL: begin
            cool_cnt_nxt = cool_cnt - 1'b1;
            if (cool_cnt <= CNT_W'(1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // outputs decode registers only, so reset drops them without a clock edge
   assign mag_on   = (state == RUN) && (phase < power_q);
   assign active   = (state == RUN);
   assign cooldown = (state == COOL);

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Bench for magnetron_ctrl: two instances (MIN_OFF=8 and MIN_OFF=0) share all
// stimulus and are compared against a cycle-count model plus fixed vectors.
module tb_magnetron_ctrl;

   logic       clk;
   logic       rst_n;
   logic       set;
   logic       reset;
   logic       door_open;
   logic [3:0] power;
   logic       mag_on8, active8, cooldown8;
   logic       mag_on0, active0, cooldown0;
   logic [1:0] mag_v, act_v, cool_v;

   int checks   = 0;
   int failures = 0;

   // model state per instance: index 0 is MIN_OFF=8, index 1 is MIN_OFF=0
   bit m_run [2];
   int m_cyc [2];
   int m_pq  [2];
   int m_cool[2];

   typedef struct {
      bit       set;
      bit       reset;
      bit       door;
      bit [3:0] power;
      bit       exp_mag;
      bit       exp_act;
      bit       exp_cool;
   } vec_t;

   vec_t vecs[8];

   magnetron_ctrl #(.PWR_W(4), .MIN_OFF(8)) dut (
      .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .door_open(door_open),
      .power(power), .mag_on(mag_on8), .active(active8), .cooldown(cooldown8)
   );

   magnetron_ctrl #(.PWR_W(4), .MIN_OFF(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .door_open(door_open),
      .power(power), .mag_on(mag_on0), .active(active0), .cooldown(cooldown0)
   );

   assign mag_v  = {mag_on0, mag_on8};
   assign act_v  = {active0, active8};
   assign cool_v = {cooldown0, cooldown8};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int moff(input int i);
      return (i == 0) ? 8 : 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_run[i]  = 0;
         m_cyc[i]  = 0;
         m_pq[i]   = 0;
         m_cool[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (m_cool[i] > 0) begin
            m_cool[i]--;
         end else if (m_run[i]) begin
            if (reset || door_open) begin
               m_run[i]  = 0;
               m_cool[i] = moff(i);
            end else begin
               m_cyc[i]++;
               if (m_cyc[i] % 16 == 0) m_pq[i] = int'(power);
            end
         end else if (set && !reset && !door_open) begin
            m_run[i] = 1;
            m_cyc[i] = 0;
            m_pq[i]  = int'(power);
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         int exp_mag;
         exp_mag = (m_run[i] && ((m_cyc[i] % 16) < m_pq[i])) ? 1 : 0;
         check($sformatf("model_mag%0d", i), int'(mag_v[i]), exp_mag);
         check($sformatf("model_act%0d", i), int'(act_v[i]), int'(m_run[i]));
         check($sformatf("model_cool%0d", i), int'(cool_v[i]), (m_cool[i] > 0) ? 1 : 0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      set = 0; reset = 0; door_open = 0;
   endtask

   task automatic drain();
      idle_inputs();
      repeat (10) step();
   endtask

   initial begin
      int cnt;
      int any_high;

      // set, reset, door, power, mag, act, cool  (MIN_OFF=8 instance)
      vecs[0] = '{1, 1, 0, 4'd3, 0, 0, 0};
      vecs[1] = '{1, 0, 1, 4'd3, 0, 0, 0};
      vecs[2] = '{1, 0, 0, 4'd3, 1, 1, 0};
      vecs[3] = '{0, 0, 0, 4'd3, 1, 1, 0};
      vecs[4] = '{0, 0, 0, 4'd3, 1, 1, 0};
      vecs[5] = '{0, 0, 0, 4'd3, 0, 1, 0};
      vecs[6] = '{1, 1, 0, 4'd3, 0, 0, 1};
      vecs[7] = '{1, 0, 0, 4'd3, 0, 0, 1};

      // reset held with a start request and full power
      model_reset();
      rst_n = 0; set = 1; reset = 0; door_open = 0; power = 4'd15;
      repeat (3) step();
      check("rst_mag", int'(mag_on8), 0);
      check("rst_act", int'(active8), 0);
      check("rst_cool", int'(cooldown8), 0);
      rst_n = 1;
      step();
      check("start_after_rst_act", int'(active8), 1);
      check("start_after_rst_mag", int'(mag_on8), 1);
      set = 0; reset = 1;
      step();
      drain();

      // vector table
      for (int v = 0; v < 8; v++) begin
         set = vecs[v].set; reset = vecs[v].reset;
         door_open = vecs[v].door; power = vecs[v].power;
         step();
         check($sformatf("vec%0d_mag", v), int'(mag_on8), int'(vecs[v].exp_mag));
         check($sformatf("vec%0d_act", v), int'(active8), int'(vecs[v].exp_act));
         check($sformatf("vec%0d_cool", v), int'(cooldown8), int'(vecs[v].exp_cool));
         if (v == 6) begin
            check("min_off0_stop_act", int'(active0), 0);
            check("min_off0_stop_cool", int'(cooldown0), 0);
         end
      end
      drain();

      // duty cycle at power 5 over three periods
      set = 1; power = 4'd5;
      step();
      set = 0;
      cnt = int'(mag_on8);
      repeat (47) begin
         step();
         cnt += int'(mag_on8);
      end
      check("duty_48", cnt, 15);

      // power change mid-period takes effect next period
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         cnt += int'(mag_on8);
         if (i == 7) power = 4'd12;
      end
      check("pwr_chg_cur_period", cnt, 5);
      cnt = 0;
      repeat (16) begin
         step();
         cnt += int'(mag_on8);
      end
      check("pwr_chg_next_period", cnt, 12);
      reset = 1;
      step();
      drain();

      // door interlock with set held high
      set = 1; power = 4'd15;
      repeat (3) step();
      door_open = 1;
      step();
      check("door_mag", int'(mag_on8), 0);
      check("door_cool", int'(cooldown8), 1);
      check("door_min_off0_act", int'(active0), 0);
      cnt = int'(cooldown8);
      repeat (12) begin
         step();
         cnt += int'(cooldown8);
         check("door_no_restart", int'(active8), 0);
      end
      check("door_cool_len", cnt, 8);
      door_open = 0;
      step();
      check("door_restart_act", int'(active8), 1);
      set = 0; reset = 1;
      step();
      drain();

      // zero power run, then async reset mid-run
      set = 1; power = 4'd0;
      step();
      check("p0_act", int'(active8), 1);
      set = 0;
      any_high = 0;
      repeat (20) begin
         step();
         if (mag_on8) any_high = 1;
      end
      check("p0_never_on", any_high, 0);
      power = 4'd15;
      repeat (16) step();
      check("p15_running", int'(active8), 1);
      #2 rst_n = 0;
      #1;
      model_reset();
      check("async_mag", int'(mag_on8), 0);
      check("async_act", int'(active8), 0);
      check("async_cool", int'(cooldown8), 0);
      check("async_act0", int'(active0), 0);
      step();
      rst_n = 1;
      step();

      // randomized stimulus against the model
      repeat (600) begin
         set       = ($urandom_range(0, 2) == 0);
         reset     = ($urandom_range(0, 9) == 0);
         door_open = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 7) == 0) power = 4'($urandom_range(0, 15));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
